// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 8-bit binary load, multi-cycle double-dabble BCD
// conversion, and a time-multiplexed 3-digit 7-segment scan on one shared bus.
module seg7_scan_controller #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg_out,
    output logic [2:0]  digit_en
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [2:0]          digit_en_q, digit_en_d;
    logic [6:0]          seg_q, seg_d;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

    // BCD digit to active-high segments (bit0=a .. bit6=g); non-decimal is dark.
    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Load handshake and one shift-add-3 iteration per cycle while converting.
    always_comb begin
        logic [BCD_W-1:0]        adj;
        logic [BCD_W+DATA_W-1:0] shifted;
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        adj       = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted   = {adj, shift_q} << 1;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (load_valid && ready_q) begin
                    state_d   = CONV;
                    shift_d   = load_data;
                    scratch_d = '0;
                    iter_d    = '0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            CONV: begin
                scratch_d = shifted[BCD_W+DATA_W-1:DATA_W];
                shift_d   = shifted[DATA_W-1:0];
                iter_d    = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(7)) begin
                    state_d = IDLE;
                    bcd_d   = shifted[BCD_W+DATA_W-1:DATA_W];
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan; segments follow the enable that is about to be driven.
    always_comb begin
        logic       wrap;
        logic [3:0] nib;
        logic       blank;
        wrap       = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        scan_cnt_d = wrap ? '0 : scan_cnt_q + CNT_W'(1);
        digit_en_d = wrap ? {digit_en_q[1:0], digit_en_q[2]} : digit_en_q;
        nib        = bcd_q[3:0];
        blank      = 1'b0;
        case (digit_en_d)
            3'b100: begin
                nib   = bcd_q[11:8];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
            end
            3'b010: begin
                nib   = bcd_q[7:4];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            default: begin
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
        endcase
        seg_d = blank ? 7'h00 : seg_enc(nib);
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            scan_cnt_q <= '0;
            digit_en_q <= 3'b001;
            seg_q      <= 7'h3F;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            iter_q     <= iter_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            scan_cnt_q <= scan_cnt_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign bcd_out    = bcd_q;
    assign seg_out    = seg_q;
    assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: directed table, handshake/reset sequences,
// and random loads checked against a decimal-arithmetic reference model.
module tb_seg7_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [7:0]  load_data;

    logic        load_ready_a, busy_a, load_ready_b, busy_b;
    logic [11:0] bcd_out_a, bcd_out_b;
    logic [6:0]  seg_out_a, seg_out_b;
    logic [2:0]  digit_en_a, digit_en_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_val  = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    seg7_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_a), .busy(busy_a), .bcd_out(bcd_out_a),
        .seg_out(seg_out_a), .digit_en(digit_en_a)
    );

    seg7_scan_controller #(.SCAN_DIV(3), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_b), .busy(busy_b), .bcd_out(bcd_out_b),
        .seg_out(seg_out_b), .digit_en(digit_en_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) + (((v / 10) % 10) << 4) + (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input logic [2:0] en, input bit blank);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (en)
            3'b100:  return (blank && h == 0) ? 7'h00 : seg_tab[h];
            3'b010:  return (blank && h == 0 && t == 0) ? 7'h00 : seg_tab[t];
            3'b001:  return seg_tab[o];
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one value and follow the conversion to completion.
    task automatic do_load(input int v);
        int   busy_cnt;
        bit   held;
        logic [11:0] prev;
        prev = to_bcd(cur_val);
        check("ready_before_load", 32'(load_ready_a), 32'd1);
        load_valid = 1'b1;
        load_data  = 8'(v);
        tick();
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        busy_cnt   = 0;
        held       = 1'b1;
        for (int i = 0; i < 20 && busy_a; i++) begin
            busy_cnt++;
            if (bcd_out_a !== prev || load_ready_a !== 1'b0) held = 1'b0;
            tick();
        end
        check("busy_cycles", 32'(busy_cnt), 32'd8);
        check("bcd_held_during_conv", 32'(held), 32'd1);
        check("bcd_a", 32'(bcd_out_a), 32'(to_bcd(v)));
        check("bcd_b", 32'(bcd_out_b), 32'(to_bcd(v)));
        cur_val = v;
    endtask

    // Watch the display on both instances for a full rotation of each.
    task automatic scan_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("onehot", {30'd0, $onehot(digit_en_a), $onehot(digit_en_b)}, 32'd3);
            check("seg_a_blank", 32'(seg_out_a), 32'(exp_seg(cur_val, digit_en_a, 1'b1)));
            check("seg_b_noblank", 32'(seg_out_b), 32'(exp_seg(cur_val, digit_en_b, 1'b0)));
        end
    endtask

    // Called right after reset release on a falling edge.
    task automatic scan_timing();
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("scan_order_a", 32'(digit_en_a), 32'(3'b001 << ((k / 4) % 3)));
            check("scan_order_b", 32'(digit_en_b), 32'(3'b001 << ((k / 3) % 3)));
        end
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_bcd"}, {bcd_out_a, bcd_out_b}, 32'd0);
        check({tag, "_busy"}, {busy_a, busy_b}, 32'd0);
        check({tag, "_ready"}, {load_ready_a, load_ready_b}, 32'd3);
        check({tag, "_digit_en"}, {digit_en_a, digit_en_b}, {26'd0, 3'b001, 3'b001});
        check({tag, "_seg"}, {seg_out_a, seg_out_b}, {18'd0, 7'h3F, 7'h3F});
    endtask

    typedef struct {
        logic [7:0]  val;
        logic [11:0] bcd;
        logic [6:0]  h_seg;
        logic [6:0]  t_seg;
        logic [6:0]  o_seg;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [6:0] want;
        int         busy_cnt;

        vecs[0] = '{8'd255, 12'h255, 7'h5B, 7'h6D, 7'h6D};
        vecs[1] = '{8'd7,   12'h007, 7'h00, 7'h00, 7'h07};
        vecs[2] = '{8'd105, 12'h105, 7'h06, 7'h3F, 7'h6D};
        vecs[3] = '{8'd0,   12'h000, 7'h00, 7'h00, 7'h3F};
        vecs[4] = '{8'd10,  12'h010, 7'h00, 7'h06, 7'h3F};
        vecs[5] = '{8'd100, 12'h100, 7'h06, 7'h3F, 7'h3F};
        vecs[6] = '{8'd99,  12'h099, 7'h00, 7'h6F, 7'h6F};
        vecs[7] = '{8'd1,   12'h001, 7'h00, 7'h00, 7'h06};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        #12;
        reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        scan_timing();

        // Directed table: conversion result and blanked scan on instance A.
        foreach (vecs[n]) begin
            do_load(int'(vecs[n].val));
            check("table_bcd", 32'(bcd_out_a), 32'(vecs[n].bcd));
            for (int i = 0; i < 12; i++) begin
                tick();
                case (digit_en_a)
                    3'b100:  want = vecs[n].h_seg;
                    3'b010:  want = vecs[n].t_seg;
                    default: want = vecs[n].o_seg;
                endcase
                check("table_seg", 32'(seg_out_a), 32'(want));
            end
            scan_check(12);
        end

        // Held valid: data changes while busy, only the first value is taken.
        tick();
        load_valid = 1'b1;
        load_data  = 8'd42;
        tick();
        check("hs_busy_after_accept", 32'(busy_a), 32'd1);
        load_data = 8'd99;
        busy_cnt  = 0;
        for (int i = 0; i < 20 && busy_a; i++) begin
            busy_cnt++;
            tick();
        end
        check("hs_busy_cycles_42", 32'(busy_cnt), 32'd8);
        check("hs_bcd_42", 32'(bcd_out_a), 32'h042);
        check("hs_ready_again", 32'(load_ready_a), 32'd1);
        tick();
        load_valid = 1'b0;
        check("hs_second_accept", 32'(busy_a), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 20 && busy_a; i++) begin
            busy_cnt++;
            if (bcd_out_a !== 12'h042) check("hs_hold_42", 32'(bcd_out_a), 32'h042);
            tick();
        end
        check("hs_busy_cycles_99", 32'(busy_cnt), 32'd8);
        check("hs_bcd_99", 32'(bcd_out_a), 32'h099);
        cur_val = 99;
        scan_check(12);

        // Reset during the 4th conversion cycle of 200 discards it.
        load_valid = 1'b1;
        load_data  = 8'd200;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("abort");
        @(negedge clk);
        rst_n   = 1'b1;
        cur_val = 0;
        scan_timing();
        check("abort_bcd_after", {bcd_out_a, bcd_out_b}, 32'd0);
        check("abort_busy_after", {busy_a, busy_b}, 32'd0);

        // Random loads against the decimal model.
        for (int r = 0; r < 20; r++) begin
            do_load(int'($urandom_range(0, 255)));
            scan_check(12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
Sequential display controller for the 3-digit 7-segment output path. It accepts an 8-bit binary value over a valid/ready handshake and converts it to three BCD digits with a multi-cycle shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one shared 7-bit segment bus with one-hot digit enables, for boards that have a single segment bus instead of three dedicated ones.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances; legal range >= 1
BLANK_LZ, 1, 1 = blank leading zeros on the hundreds and tens digits; 0 = always display all digits

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load_data is valid
load_data  input  8  unsigned binary value, 0..255
load_ready  output  1  high when the controller can accept a load
busy  output  1  high while a conversion is in progress
bcd_out  output  12  displayed digits: [11:8] hundreds, [7:4] tens, [3:0] ones
seg_out  output  7  segment drive, active-high; bit0=a, bit1=b, ..., bit6=g
digit_en  output  3  one-hot digit enable, active-high; bit2 hundreds, bit1 tens, bit0 ones

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - FSM = IDLE; bcd_out = 0x000; busy = 0; load_ready = 1.
  - Scan counter = 0; digit_en = 3'b001; seg_out = 7'h3F (ones digit showing "0").
- FSM states: IDLE, CONV.
  - IDLE: load_ready = 1, busy = 0.
  - IDLE -> CONV on load_valid & load_ready. The handshake cycle captures load_data into an 8-bit shift register, clears a 12-bit BCD scratch register and sets the iteration count to 0.
  - CONV: load_ready = 0, busy = 1. Each cycle:
    - add 3 to every scratch nibble >= 5;
    - shift {scratch, shift_reg} left by 1;
    - increment the iteration count.
  - CONV -> IDLE after exactly 8 iterations. On the 8th-iteration edge the final scratch value is written to bcd_out.
- Latency: with the accept on edge N, busy is high for edges N+1..N+8 and bcd_out updates on edge N+8. The earliest next accept is the handshake cycle after edge N+8.
- load_valid while load_ready=0 is ignored; there is no queueing. The source must hold valid until the handshake completes.
- bcd_out and the display keep the previous value for the whole conversion. There is no partial-value glitch.
- Scan:
  - Free-running counter 0..SCAN_DIV-1, independent of the FSM.
  - On wrap, digit_en rotates 001 -> 010 -> 100 -> 001.
  - With SCAN_DIV=1 it advances every cycle.
  - digit_en is always exactly one-hot.
- seg_out is registered. It is updated on the same edge as digit_en, from the selected digit of the current bcd_out, so the segments and the enable never mismatch.
- Segment codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Nibbles > 9 cannot occur; drive 7'h00 if they do.
- Blanking (BLANK_LZ=1):
  - The hundreds digit is blank when hundreds = 0.
  - The tens digit is blank when hundreds = 0 and tens = 0.
  - The ones digit is never blank.
  - A blank digit drives seg_out = 7'h00 while its digit_en stays asserted.
- Reset mid-conversion aborts the conversion, returns to the reset values above and discards the pending value.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs change immediately: digit_en=001, seg_out=7'h3F, bcd_out=0x000, load_ready=1, busy=0.
- Load 255: pulse load_valid with load_data=8'hFF -> busy high for exactly 8 cycles, then bcd_out=0x255. The scan shows hundreds=5B, tens=6D, ones=6D.
- Blanking: load 7 with BLANK_LZ=1 -> bcd_out=0x007; seg_out=00 while digit_en=100 or 010, and 07 while digit_en=001. With BLANK_LZ=0: 3F, 3F, 07.
- Inner zero: load 105 -> bcd_out=0x105; the tens digit shows 3F and is not blanked.
- Handshake: hold load_valid with data 42 and then change the data to 99 while busy -> only 42 is converted. 99 is accepted on the first ready cycle and bcd_out=0x099 appears 8 cycles later. Hundreds is blank.
- Scan timing and reset abort: SCAN_DIV=4 -> digit_en changes every 4 cycles in the order 001, 010, 100, 001. Asserting rst_n=0 at the 4th conversion cycle of load 200 -> bcd_out stays 0x000 after release.
